// File: rtl/psram_mem_tester.sv
// PSRAM memory tester: writes a selectable pattern over a block of PSRAM
// words through the controller app_* handshake, reads the block back,
// compares every word and reports error count, first failing address/data,
// pass/fail and a handshake watchdog timeout.
module psram_mem_tester #(
    parameter int                ADDR_W    = 23,
    parameter int                DATA_W    = 16,
    parameter int                NUM_WORDS = 256,
    parameter int                BASE_ADDR = 0,
    parameter logic [DATA_W-1:0] CONST_PAT = 16'hBABE,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic              app_ctrlr_good,
    input  logic              app_op_begun,
    input  logic              op_finished,
    input  logic [DATA_W-1:0] app_data_out,
    output logic              app_wr,
    output logic              app_rd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [DATA_W-1:0] app_data_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_word
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_GOOD = 3'd1,
        WR_REQ    = 3'd2,
        WR_WAIT   = 3'd3,
        RD_REQ    = 3'd4,
        RD_WAIT   = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int                WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    // Expected data word for a given pattern mode and word index.
    function automatic logic [DATA_W-1:0] pattern_f(input logic [1:0] sel,
                                                    input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] alt;
        logic [DATA_W-1:0] res;
        // Odd index -> 1010.. (AAAA), even index -> 0101.. (5555)
        for (int i = 0; i < DATA_W; i++) begin
            alt[i] = ~(idx[0] ^ i[0]);
        end
        case (sel)
            2'd0:    res = DATA_W'(idx);
            2'd1:    res = CONST_PAT;
            2'd2:    res = alt;
            2'd3:    res = ~DATA_W'(idx);
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // True for the states that wait on the controller (watchdog-guarded).
    function automatic logic is_hs_f(input state_t st);
        return (st == WR_REQ) || (st == WR_WAIT) || (st == RD_REQ) || (st == RD_WAIT);
    endfunction

    state_t              state_r,     state_nx_s;
    logic [ADDR_W-1:0]   index_r,     index_nx_s;
    logic [1:0]          mode_r,      mode_nx_s;
    logic [WD_W-1:0]     wdog_r,      wdog_nx_s;
    logic [15:0]         err_count_r, err_nx_s;
    logic [ADDR_W-1:0]   fail_addr_r, fail_addr_nx_s;
    logic [DATA_W-1:0]   fail_data_r, fail_data_nx_s;
    logic                timeout_r,   timeout_nx_s;
    logic                pass_r,      pass_nx_s;
    logic                rd_valid_r,  rd_valid_nx_s;
    logic [DATA_W-1:0]   rd_word_r,   rd_word_nx_s;
    logic                app_wr_r, app_rd_r, busy_r, done_r;
    logic [ADDR_W-1:0]   app_addr_r;
    logic [DATA_W-1:0]   app_data_in_r;
    logic                wd_hit_s;
    logic [DATA_W-1:0]   rd_exp_s;

    // Next-state, index, watchdog and result bookkeeping.
    always_comb begin
        state_nx_s     = state_r;
        index_nx_s     = index_r;
        mode_nx_s      = mode_r;
        err_nx_s       = err_count_r;
        fail_addr_nx_s = fail_addr_r;
        fail_data_nx_s = fail_data_r;
        timeout_nx_s   = timeout_r;
        pass_nx_s      = pass_r;
        rd_valid_nx_s  = 1'b0;
        rd_word_nx_s   = rd_word_r;
        wd_hit_s       = (wdog_r == WD_LAST);
        rd_exp_s       = pattern_f(mode_r, index_r);

        if (abort && (state_r != IDLE)) begin
            // Cancel: results so far are kept for inspection
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_nx_s     = WAIT_GOOD;
                        mode_nx_s      = mode;
                        index_nx_s     = {ADDR_W{1'b0}};
                        err_nx_s       = 16'h0000;
                        fail_addr_nx_s = {ADDR_W{1'b0}};
                        fail_data_nx_s = {DATA_W{1'b0}};
                        timeout_nx_s   = 1'b0;
                        pass_nx_s      = 1'b0;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                WAIT_GOOD: begin
                    if (app_ctrlr_good) begin
                        state_nx_s = WR_REQ;
                        index_nx_s = {ADDR_W{1'b0}};
                    end else begin
                        state_nx_s = WAIT_GOOD;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (app_op_begun) begin
                        state_nx_s = (state_r == WR_REQ) ? WR_WAIT : RD_WAIT;
                    end else if (wd_hit_s) begin
                        state_nx_s   = DONE;
                        timeout_nx_s = 1'b1;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                WR_WAIT: begin
                    if (op_finished) begin
                        if (index_r == LAST_IDX) begin
                            state_nx_s = RD_REQ;
                            index_nx_s = {ADDR_W{1'b0}};
                        end else begin
                            state_nx_s = WR_REQ;
                            index_nx_s = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end else if (wd_hit_s) begin
                        state_nx_s   = DONE;
                        timeout_nx_s = 1'b1;
                    end else begin
                        state_nx_s = WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (op_finished) begin
                        rd_valid_nx_s = 1'b1;
                        rd_word_nx_s  = app_data_out;
                        if (app_data_out != rd_exp_s) begin
                            // Only the first mismatch of a run is latched
                            if (err_count_r == 16'h0000) begin
                                fail_addr_nx_s = BASE_A + index_r;
                                fail_data_nx_s = app_data_out;
                            end else begin
                                fail_addr_nx_s = fail_addr_r;
                            end
                            if (err_count_r != 16'hFFFF) begin
                                err_nx_s = err_count_r + 16'd1;
                            end else begin
                                err_nx_s = err_count_r;
                            end
                        end else begin
                            err_nx_s = err_count_r;
                        end
                        if (index_r == LAST_IDX) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = RD_REQ;
                            index_nx_s = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end else if (wd_hit_s) begin
                        state_nx_s   = DONE;
                        timeout_nx_s = 1'b1;
                    end else begin
                        state_nx_s = RD_WAIT;
                    end
                end
                default: state_nx_s = IDLE;
            endcase
        end

        if (state_nx_s == DONE) begin
            pass_nx_s = (err_nx_s == 16'h0000) && !timeout_nx_s;
        end else begin
            pass_nx_s = pass_nx_s;
        end

        // Watchdog restarts on every state change and idles outside handshakes
        if (is_hs_f(state_nx_s) && (state_nx_s == state_r)) begin
            wdog_nx_s = wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_nx_s = {WD_W{1'b0}};
        end
    end

    // State, status and registered controller-side outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r       <= IDLE;
            index_r       <= {ADDR_W{1'b0}};
            mode_r        <= 2'd0;
            wdog_r        <= {WD_W{1'b0}};
            err_count_r   <= 16'h0000;
            fail_addr_r   <= {ADDR_W{1'b0}};
            fail_data_r   <= {DATA_W{1'b0}};
            timeout_r     <= 1'b0;
            pass_r        <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_word_r     <= {DATA_W{1'b0}};
            app_wr_r      <= 1'b0;
            app_rd_r      <= 1'b0;
            app_addr_r    <= {ADDR_W{1'b0}};
            app_data_in_r <= {DATA_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            index_r       <= index_nx_s;
            mode_r        <= mode_nx_s;
            wdog_r        <= wdog_nx_s;
            err_count_r   <= err_nx_s;
            fail_addr_r   <= fail_addr_nx_s;
            fail_data_r   <= fail_data_nx_s;
            timeout_r     <= timeout_nx_s;
            pass_r        <= pass_nx_s;
            rd_valid_r    <= rd_valid_nx_s;
            rd_word_r     <= rd_word_nx_s;
            app_wr_r      <= (state_nx_s == WR_REQ);
            app_rd_r      <= (state_nx_s == RD_REQ);
            app_addr_r    <= is_hs_f(state_nx_s) ? (BASE_A + index_nx_s) : {ADDR_W{1'b0}};
            app_data_in_r <= (state_nx_s == WR_REQ) ? pattern_f(mode_nx_s, index_nx_s)
                                                    : {DATA_W{1'b0}};
            busy_r        <= (state_nx_s != IDLE) && (state_nx_s != DONE);
            done_r        <= (state_nx_s == DONE);
        end
    end

    assign app_wr      = app_wr_r;
    assign app_rd      = app_rd_r;
    assign app_addr    = app_addr_r;
    assign app_data_in = app_data_in_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign timeout     = timeout_r;
    assign err_count   = err_count_r;
    assign fail_addr   = fail_addr_r;
    assign fail_data   = fail_data_r;
    assign rd_valid    = rd_valid_r;
    assign rd_word     = rd_word_r;

endmodule

// File: tb/tb_psram_mem_tester.sv
// Self-checking bench for psram_mem_tester: a behavioural PSRAM controller
// with random handshake latency and injectable read corruption, a table of
// directed runs, randomized runs against a pattern model, and hand-written
// sequences for good-wait, timeout, abort and mid-run reset.
module tb_psram_mem_tester;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int BASE = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic clr_n, start, abort, app_ctrlr_good, app_op_begun, op_finished;
    logic [1:0] mode;
    logic [DW-1:0] app_data_out, app_data_in, fail_data, rd_word;
    logic app_wr, app_rd, busy, done, pass, timeout, rd_valid;
    logic [AW-1:0] app_addr, fail_addr;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    psram_mem_tester #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .CONST_PAT(16'hBABE), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .mode(mode),
        .app_ctrlr_good(app_ctrlr_good), .app_op_begun(app_op_begun),
        .op_finished(op_finished), .app_data_out(app_data_out),
        .app_wr(app_wr), .app_rd(app_rd), .app_addr(app_addr), .app_data_in(app_data_in),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
        .rd_valid(rd_valid), .rd_word(rd_word)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Controller model controls and logs
    int ctl_gen = 0;
    bit mute_begun = 1'b0;
    bit fixed_lat = 1'b0;
    logic [3:0] ctl_mask = 4'b0;
    logic [3:0][15:0] ctl_vals = '0;
    logic [AW-1:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] mem[int];
    int overlap_cnt = 0;

    // High-level pattern model
    function automatic logic [15:0] exp_pat(input logic [1:0] m, input int i);
        case (m)
            2'd0:    return 16'(i);
            2'd1:    return 16'hBABE;
            2'd2:    return (i % 2 == 1) ? 16'hAAAA : 16'h5555;
            default: return 16'hFFFF - 16'(i);
        endcase
    endfunction

    // Behavioural PSRAM controller
    initial begin : ctl_model
        int phase, cnt, seen_gen, idx;
        logic is_rd;
        logic [AW-1:0] a;
        phase = 0; cnt = 0; seen_gen = 0; is_rd = 1'b0; a = '0;
        app_op_begun = 1'b0; op_finished = 1'b0; app_data_out = 16'h0;
        forever begin
            @(negedge clk);
            app_op_begun = 1'b0;
            op_finished  = 1'b0;
            if (app_wr && app_rd) overlap_cnt++;
            if (seen_gen != ctl_gen) begin
                seen_gen = ctl_gen;
                phase = 0;
            end else if (phase == 0) begin
                if (app_wr || app_rd) begin
                    is_rd = app_rd; a = app_addr;
                    cnt = fixed_lat ? 0 : int'($urandom_range(0, 2));
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (!mute_begun) begin
                    if (cnt == 0) begin
                        app_op_begun = 1'b1;
                        if (!is_rd) begin
                            wr_addr_q.push_back(a);
                            wr_data_q.push_back(app_data_in);
                            mem[int'(a)] = app_data_in;
                        end
                        cnt = fixed_lat ? 2 : int'($urandom_range(0, 2));
                        phase = 2;
                    end else cnt--;
                end
            end else begin
                if (cnt == 0) begin
                    op_finished = 1'b1;
                    if (is_rd) begin
                        idx = int'(a) - BASE;
                        if (idx >= 0 && idx < 4 && ctl_mask[idx]) app_data_out = ctl_vals[idx];
                        else if (mem.exists(int'(a))) app_data_out = mem[int'(a)];
                        else app_data_out = 16'h0;
                    end
                    phase = 0;
                end else cnt--;
            end
        end
    end

    // Read-result monitor
    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (rd_valid) rd_q.push_back(rd_word);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete(); mem.delete();
        ctl_gen++;
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk({name, "_done"}, done, 1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_ctl"}, {app_wr, app_rd, busy, done, pass, timeout, rd_valid}, 0);
        chk({p, "_addr"}, app_addr, 0);
        chk({p, "_wdata"}, app_data_in, 0);
        chk({p, "_err"}, err_count, 0);
        chk({p, "_faddr"}, fail_addr, 0);
        chk({p, "_fdata"}, fail_data, 0);
        chk({p, "_rword"}, rd_word, 0);
    endtask

    task automatic run_vec(input string name, input logic [1:0] m, input logic [3:0] mask,
                           input logic [3:0][15:0] vals, input logic [15:0] e_err,
                           input logic [AW-1:0] e_fa, input logic [15:0] e_fd, input logic e_pass);
        logic [15:0] er;
        ctl_mask = mask; ctl_vals = vals;
        clear_logs();
        do_start(m);
        wait_done(name);
        chk({name, "_err"}, err_count, e_err);
        chk({name, "_faddr"}, fail_addr, e_fa);
        chk({name, "_fdata"}, fail_data, e_fd);
        chk({name, "_pass"}, pass, e_pass);
        chk({name, "_tmo"}, timeout, 0);
        chk({name, "_nwr"}, wr_addr_q.size(), NW);
        chk({name, "_nrd"}, rd_q.size(), NW);
        for (int i = 0; i < NW; i++) begin
            if (i < wr_addr_q.size()) begin
                chk($sformatf("%s_wa%0d", name, i), wr_addr_q[i], BASE + i);
                chk($sformatf("%s_wd%0d", name, i), wr_data_q[i], exp_pat(m, i));
            end
            if (i < rd_q.size()) begin
                er = mask[i] ? vals[i] : exp_pat(m, i);
                chk($sformatf("%s_rd%0d", name, i), rd_q[i], er);
            end
        end
    endtask

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [3:0]       mask;
        logic [3:0][15:0] vals;
        logic [15:0]      e_err;
        logic [AW-1:0]    e_fa;
        logic [15:0]      e_fd;
        logic             e_pass;
    } vec_t;

    vec_t tbl[6];

    initial begin : main
        int viol, n;
        logic [1:0] m;
        logic [3:0] mask;
        logic [3:0][15:0] vals;
        logic [15:0] e_err, e_fd;
        logic [AW-1:0] e_fa;

        tbl[0] = '{"m0_clean", 2'd0, 4'b0000, 64'h0, 16'd0, 23'h0, 16'h0, 1'b1};
        tbl[1] = '{"m0_dead", 2'd0, 4'b0100, {16'h0000, 16'hDEAD, 16'h0000, 16'h0000},
                   16'd1, 23'h12, 16'hDEAD, 1'b0};
        tbl[2] = '{"m1_clean", 2'd1, 4'b0000, 64'h0, 16'd0, 23'h0, 16'h0, 1'b1};
        tbl[3] = '{"m2_bad0", 2'd2, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h5554},
                   16'd1, 23'h10, 16'h5554, 1'b0};
        tbl[4] = '{"m3_same", 2'd3, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                   16'd0, 23'h0, 16'h0, 1'b1};
        tbl[5] = '{"m0_two", 2'd0, 4'b1010, {16'h3333, 16'h0000, 16'h1111, 16'h0000},
                   16'd2, 23'h11, 16'h1111, 1'b0};

        clr_n = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; app_ctrlr_good = 1'b1;
        #1 clr_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        clr_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", {app_wr, app_rd, busy}, 0);

        // Directed table
        for (int t = 0; t < 6; t++)
            run_vec(tbl[t].name, tbl[t].mode, tbl[t].mask, tbl[t].vals,
                    tbl[t].e_err, tbl[t].e_fa, tbl[t].e_fd, tbl[t].e_pass);

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(0, 3));
            mask = 4'($urandom_range(0, 15));
            e_err = 16'd0; e_fa = '0; e_fd = 16'h0;
            for (int i = 0; i < 4; i++) begin
                vals[i] = ($urandom_range(0, 1) == 1) ? exp_pat(m, i) : 16'($urandom);
                if (mask[i] && vals[i] != exp_pat(m, i)) begin
                    if (e_err == 16'd0) begin e_fa = AW'(BASE + i); e_fd = vals[i]; end
                    e_err++;
                end
            end
            run_vec($sformatf("rnd%0d", r), m, mask, vals, e_err, e_fa, e_fd, e_err == 16'd0);
        end

        // Controller not ready for 50 cycles
        app_ctrlr_good = 1'b0; ctl_mask = 4'b0; clear_logs();
        do_start(2'd0);
        viol = 0;
        repeat (50) begin
            if (!busy || app_wr || app_rd) viol++;
            @(negedge clk);
        end
        chk("good_hold_viol", viol, 0);
        chk("good_hold_nwr", wr_addr_q.size(), 0);
        app_ctrlr_good = 1'b1;
        n = 0;
        while (!app_wr && n < 10) begin @(negedge clk); n++; end
        chk("good_first_wr", app_wr, 1);
        chk("good_first_addr", app_addr, BASE);
        wait_done("good");
        chk("good_pass", pass, 1);

        // Handshake timeout
        mute_begun = 1'b1; clear_logs();
        do_start(2'd0);
        n = 0;
        while (!app_wr && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (app_wr && n < 100) begin n++; @(negedge clk); end
        chk("to_wr_cycles", n, TO);
        chk("to_done", done, 1);
        chk("to_flag", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_wr_low", {app_wr, busy}, 0);
        mute_begun = 1'b0; ctl_gen++;
        @(negedge clk);

        // Abort during a read wait, then a fresh mode-1 run
        fixed_lat = 1'b1; clear_logs();
        ctl_mask = 4'b0001; ctl_vals = {16'h0, 16'h0, 16'h0, 16'h0BAD};
        do_start(2'd0);
        n = 0;
        while (rd_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
        while (!app_rd && n < 500) begin @(negedge clk); n++; end
        while (app_rd && n < 500) begin @(negedge clk); n++; end
        chk("abort_reach", n < 500, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ctl_gen++;
        chk("abort_ctl", {busy, done, app_rd, app_wr}, 0);
        chk("abort_err_kept", err_count, 1);
        chk("abort_faddr_kept", fail_addr, 23'h10);
        repeat (4) @(negedge clk);
        chk("abort_nrd", rd_q.size(), 2);
        clear_logs(); ctl_mask = 4'b0;
        do_start(2'd1);
        chk("restart_err_clr", err_count, 0);
        chk("restart_faddr_clr", fail_addr, 0);
        wait_done("restart");
        chk("restart_nwr", wr_data_q.size(), NW);
        for (int i = 0; i < wr_data_q.size(); i++)
            chk($sformatf("restart_wd%0d", i), wr_data_q[i], 16'hBABE);
        chk("restart_pass", pass, 1);
        fixed_lat = 1'b0;

        // Asynchronous reset in the middle of a write
        clear_logs();
        do_start(2'd2);
        n = 0;
        while (!app_wr && n < 10) begin @(negedge clk); n++; end
        #2 clr_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        #1 clr_n = 1'b1;
        ctl_gen++;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || app_wr || app_rd) viol++;
        end
        chk("midrst_quiet", viol, 0);
        run_vec("post_rst", 2'd3, 4'b0000, 64'h0, 16'd0, 23'h0, 16'h0, 1'b1);

        chk("no_wr_rd_overlap", overlap_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/psram_mem_tester.md
PSRAM_MEM_TESTER -- requirements
Module: psram_mem_tester

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 23, giving the PSRAM word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the PSRAM data width.
REQ-003 The module SHALL have parameter NUM_WORDS, default 256, giving the number of words tested per run (range 1..2^ADDR_W).
REQ-004 The module SHALL have parameter BASE_ADDR, default 0, giving the first tested address.
REQ-005 The module SHALL have parameter CONST_PAT, default 16'hBABE, giving the constant pattern for mode 1.
REQ-006 The module SHALL have parameter TIMEOUT, default 1024, giving the cycle limit per controller handshake.
REQ-007 The module SHALL have port clk, input, 1, as the single clock (the controller app_clk).
REQ-008 The module SHALL have port clr_n, input, 1, as the asynchronous active-low reset.
REQ-009 The module SHALL have port start, input, 1, a single-cycle run request.
REQ-010 The module SHALL have port abort, input, 1, a run cancel.
REQ-011 The module SHALL have port mode, input, 2, the pattern select, sampled on accepted start.
REQ-012 The controller-side ports SHALL be: app_ctrlr_good in 1; app_op_begun in 1; op_finished in 1; app_data_out in DATA_W; app_wr out 1; app_rd out 1; app_addr out ADDR_W; app_data_in out DATA_W.
REQ-013 The status ports SHALL be: busy out 1; done out 1; pass out 1; timeout out 1; err_count out 16; fail_addr out ADDR_W; fail_data out DATA_W; rd_valid out 1; rd_word out DATA_W.

Function
REQ-014 The state machine SHALL have states IDLE, WAIT_GOOD, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT and DONE.
REQ-015 IDLE SHALL go to WAIT_GOOD on start=1; start SHALL be ignored in any other state.
REQ-016 WAIT_GOOD SHALL go to WR_REQ with index=0 once app_ctrlr_good=1.
REQ-017 app_addr SHALL be BASE_ADDR+index, truncated to ADDR_W (wraps modulo 2^ADDR_W).
REQ-018 The expected pattern P(index) SHALL be: mode0 index[DATA_W-1:0]; mode1 CONST_PAT; mode2 index[0]?AAAA:5555 (replicated to DATA_W); mode3 ~index[DATA_W-1:0].
REQ-019 In WR_REQ, app_wr SHALL be 1 and app_data_in SHALL be P(index), held until app_op_begun is sampled 1, after which the state SHALL go to WR_WAIT with app_wr=0 from the next cycle.
REQ-020 In WR_WAIT, on op_finished=1, the state SHALL go to RD_REQ with index=0 if index=NUM_WORDS-1, else to WR_REQ with index+1.
REQ-021 RD_REQ and RD_WAIT SHALL mirror WR_REQ and WR_WAIT using app_rd; the final read SHALL go to DONE.
REQ-022 In RD_WAIT, app_data_out SHALL be captured on the op_finished=1 cycle; rd_valid SHALL pulse 1 cycle later with rd_word set to the captured value.
REQ-023 On a mismatch between captured data and P(index), err_count SHALL increment, saturating at 16'hFFFF.
REQ-024 On the first mismatch of a run only, fail_addr and fail_data (the read value) SHALL be latched.
REQ-025 A watchdog SHALL count cycles spent in any REQ/WAIT state, clearing on each state change; on reaching TIMEOUT the state SHALL go to DONE with timeout=1.
REQ-026 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with app_wr=app_rd=0, done=0 and status retained; abort SHALL win over start.
REQ-027 DONE SHALL assert done=1, with pass=1 iff err_count=0 and timeout=0; start in DONE SHALL be accepted as from IDLE.
REQ-028 An accepted start SHALL clear err_count, fail_addr, fail_data, timeout, done and pass.
REQ-029 busy SHALL be 1 in every state except IDLE and DONE.
REQ-030 app_wr and app_rd SHALL never be 1 simultaneously.

Reset
REQ-031 clr_n=0 SHALL force, asynchronously, state IDLE and all outputs 0 (app_addr=0, app_data_in=0, err_count=0, fail_addr=0, fail_data=0, rd_word=0), including mid-run.
REQ-032 After clr_n rises, no controller request SHALL issue until a new start is accepted.

Verification
REQ-033 NUM_WORDS=4, BASE_ADDR=0x10, mode0, ideal controller model -> writes 0,1,2,3 to 0x10..0x13, four rd_valid pulses with 0..3, done=1, pass=1, err_count=0.
REQ-034 Same run with the model returning 0xDEAD at 0x12 -> err_count=1, fail_addr=0x12, fail_data=0xDEAD, pass=0.
REQ-035 Model never asserts app_op_begun, TIMEOUT=16 -> app_wr high for 16 cycles, then done=1, timeout=1, pass=0, app_wr=0.
REQ-036 app_ctrlr_good held 0 for 50 cycles after start -> busy=1 and app_wr=0 throughout; the first write issues after good rises.
REQ-037 abort during RD_WAIT, then start with mode1 -> IDLE next cycle, then a fresh run with counters cleared and all writes equal to 0xBABE.
REQ-038 clr_n low mid-write for 1 cycle -> app_wr=0 immediately, all outputs 0, busy=0 until the next start.
